// File: rtl/tick_gen.sv
// Programmable clock-enable tick generator with a loadable divisor and an optional burst limit.
// Define TICK_GEN_BURST_EN to compile in burst mode (run ends after burst_len_i ticks).
module tick_gen #(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               div_valid_i,
  output logic               div_ready_o,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               ce_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_m1;
  logic             ce_d;

`ifdef TICK_GEN_BURST_EN
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               done_d;
`else
  logic               unused_burst;
  assign unused_burst = ^{burst_len_i, BURST_ONE};
`endif

  // A divisor of zero behaves like one, so the terminal count is never below zero.
  assign period_m1 = (div_q == '0) ? '0 : (div_q - DIV_ONE);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
`ifdef TICK_GEN_BURST_EN
    burst_d = burst_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (div_valid_i) begin
          div_d = div_i;
        end
        if (enable_i) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef TICK_GEN_BURST_EN
          burst_d = burst_len_i;
          bcnt_d  = '0;
`endif
        end
      end

      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_m1) begin
          cnt_d = '0;
          ce_d  = 1'b1;
`ifdef TICK_GEN_BURST_EN
          // The final tick of a burst and its done pulse leave together.
          if ((burst_q != '0) && (bcnt_q == (burst_q - BURST_ONE))) begin
            state_d = DONE;
            done_d  = 1'b1;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BURST_ONE;
          end
`endif
        end else begin
          cnt_d = cnt_q + DIV_ONE;
        end
      end

      DONE: begin
        if (!enable_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      div_q       <= DIV_ONE;
      cnt_q       <= '0;
      ce_o        <= 1'b0;
      busy_o      <= 1'b0;
      div_ready_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      ce_o        <= ce_d;
      busy_o      <= (state_d == RUN);
      div_ready_o <= (state_d == IDLE);
    end
  end

`ifdef TICK_GEN_BURST_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      burst_q <= '0;
      bcnt_q  <= '0;
      done_o  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      bcnt_q  <= bcnt_d;
      done_o  <= done_d;
    end
  end
`else
  assign done_o = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a cycle model pushes expected outputs as stimulus is driven,
// and they are popped and compared one clock later.
module tb_tick_gen;

  localparam int DIV_W   = 16;
  localparam int BURST_W = 8;

  logic               clk_i = 1'b0;
  logic               reset_i = 1'b0;
  logic               enable_i = 1'b0;
  logic [DIV_W-1:0]   div_i = '0;
  logic               div_valid_i = 1'b0;
  logic [BURST_W-1:0] burst_len_i = '0;
  logic               div_ready_o;
  logic               ce_o;
  logic               busy_o;
  logic               done_o;

  always #5 clk_i = ~clk_i;

  tick_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .burst_len_i (burst_len_i),
    .ce_o        (ce_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct packed {
    logic ce;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: counts cycles since the run started and ticks on multiples of the period.
  int m_state = 0;
  int m_div   = 1;
  int m_age   = 0;
  int m_ticks = 0;
  int m_blen  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input int div, input logic dv, input int blen);
    exp_t e;
    exp_t got;
    int   p;
    reset_i     = rst;
    enable_i    = en;
    div_i       = div[DIV_W-1:0];
    div_valid_i = dv;
    burst_len_i = blen[BURST_W-1:0];

    e.ce   = 1'b0;
    e.done = 1'b0;
    if (rst) begin
      m_state = 0;
      m_div   = 1;
      m_age   = 0;
      m_ticks = 0;
    end else begin
      case (m_state)
        0: begin
          if (dv) m_div = div;
          if (en) begin
            m_state = 1;
            m_age   = 0;
            m_ticks = 0;
            m_blen  = blen;
          end
        end
        1: begin
          if (!en) begin
            m_state = 0;
          end else begin
            m_age++;
            p = (m_div == 0) ? 1 : m_div;
            if (m_age % p == 0) begin
              e.ce = 1'b1;
              m_ticks++;
`ifdef TICK_GEN_BURST_EN
              if (m_blen != 0 && m_ticks == m_blen) begin
                e.done  = 1'b1;
                m_state = 2;
              end
`endif
            end
          end
        end
        default: begin
          if (!en) m_state = 0;
        end
      endcase
    end
    e.busy  = (m_state == 1);
    e.ready = (m_state == 0);
    exp_q.push_back(e);

    @(posedge clk_i);
    #1;
    cycle++;
    if (exp_q.size() == 0) begin
      checkOutput($sformatf("sb_empty@%0d", cycle), 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      checkOutput($sformatf("ce@%0d", cycle),    {31'd0, ce_o},        {31'd0, got.ce});
      checkOutput($sformatf("busy@%0d", cycle),  {31'd0, busy_o},      {31'd0, got.busy});
      checkOutput($sformatf("done@%0d", cycle),  {31'd0, done_o},      {31'd0, got.done});
      checkOutput($sformatf("ready@%0d", cycle), {31'd0, div_ready_o}, {31'd0, got.ready});
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0);

    // Divisor 4: ticks at 4, 8, 12 after enable is sampled.
    applyStimulus(1'b0, 1'b0, 4, 1'b1, 0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Divisor 0 and divisor 1 both tick every cycle; load shares the enable cycle.
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1, 1'b1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Divisor 5: drop before the first tick, then re-raise.
    applyStimulus(1'b0, 1'b1, 5, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Divisor offered during a run is ignored; reload in idle takes effect.
    applyStimulus(1'b0, 1'b1, 3, 1'b1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 9, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 9, 1'b1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Burst of 3 with divisor 2, then hold, release and restart.
    applyStimulus(1'b0, 1'b1, 2, 1'b1, 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    // Reset just before a due tick, with a competing divisor load; div_q returns to 1.
    applyStimulus(1'b0, 1'b1, 4, 1'b1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 7, 1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 8,
                    int'($urandom_range(0, 6)),
                    $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor and tick counter.
REQ-002 Parameter BURST_W, default 8, width of burst length.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 enable_i  input  1  run request, level-sensitive.
REQ-006 div_i  input  DIV_W  divisor value, period in clk_i cycles.
REQ-007 div_valid_i  input  1  div_i valid.
REQ-008 div_ready_o  output  1  divisor register may be loaded.
REQ-009 burst_len_i  input  BURST_W  tick count per run; 0 = unlimited.
REQ-010 ce_o  output  1  one-cycle clock-enable tick; drives the downstream counter ce_i.
REQ-011 busy_o  output  1  high while state is RUN.
REQ-012 done_o  output  1  one-cycle pulse when a burst completes.

Function
REQ-013 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 Internal div_q (DIV_W) holds the period; effective period P = max(div_q, 1).
REQ-015 div_ready_o = 1 only in IDLE; load div_q when div_valid_i && div_ready_o.
REQ-016 div_valid_i outside IDLE: ignored, div_q unchanged, no stall of running ticks.
REQ-017 IDLE -> RUN when enable_i = 1; tick counter cnt cleared to 0 on entry.
REQ-018 Load and enable_i in same IDLE cycle: the newly loaded div_i is used for that run.
REQ-019 In RUN, cnt increments each cycle; at cnt == P-1, cnt wraps to 0 and ce_o = 1 the next cycle.
REQ-020 First ce_o occurs exactly P cycles after the cycle enable_i is sampled high in IDLE; subsequent ticks every P cycles.
REQ-021 P = 1: ce_o high every cycle in RUN, starting 1 cycle after enable_i is sampled.
REQ-022 RUN -> IDLE when enable_i = 0: cnt cleared, no ce_o in the following cycle, pending tick discarded.
REQ-023 cnt never exceeds P-1; DIV_W-bit arithmetic never overflows.
REQ-024 busy_o = 1 exactly in the cycles the state is RUN.

Reset
REQ-025 reset_i sampled high on posedge clk_i: state IDLE, cnt 0, div_q 1, burst count 0, ce_o 0, done_o 0, busy_o 0, div_ready_o 1.
REQ-026 Reset takes priority over every other input, including mid-run and same-cycle div_valid_i.
REQ-027 Reset mid-run suppresses any tick or done_o pulse due in the following cycle.

Configuration
REQ-028 Macro TICK_GEN_BURST_EN compiles in burst mode.
REQ-029 With the macro: burst_len_i sampled on IDLE -> RUN; nonzero L ends the run after the L-th ce_o, going to DONE with done_o = 1 for one cycle, coinciding with the L-th ce_o.
REQ-030 With the macro: DONE holds, no ticks, until enable_i = 0, then IDLE; burst_len_i = 0 runs unlimited.
REQ-031 Without the macro: ports present, burst_len_i ignored, done_o tied 0, DONE state unreachable, runs are unlimited.

Verification
REQ-032 Reset, load div_i = 4, enable_i held high -> ce_o pulses at cycles 4, 8, 12 after enable sampled; busy_o high throughout.
REQ-033 div_i = 0 loaded, enable_i high -> ce_o high every cycle from cycle 1; div_i = 1 gives identical output.
REQ-034 div_i = 5, enable_i dropped 3 cycles in, re-raised -> no tick on drop, first new tick 5 cycles after re-raise.
REQ-035 div_valid_i with div_i = 9 during RUN (div_q = 3) -> div_ready_o 0, period stays 3; after return to IDLE and reload, period 9.
REQ-036 TICK_GEN_BURST_EN, div_i = 2, burst_len_i = 3 -> ce_o at cycles 2, 4, 6, done_o with the 3rd tick, no more ticks until enable_i low then high.
REQ-037 reset_i asserted on the cycle before a due tick (div_i = 4, cycle 3) -> no ce_o, all outputs at reset values next cycle.
